audio_sdm_dac: RTL and testbench

//  Playback stage directly downstream of the comb/decimation filter.
//  - Buffers signed 16-bit PCM samples in a small FIFO.
//  - Pops one sample per PCM strobe and holds it.
//  - Converts the held sample to a 1-bit PDM stream with a second-order

---
 rtl/audio_sdm_dac.sv | 149 ++++++++++++++
 tb/tb_audio_sdm_dac.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/audio_sdm_dac.sv
// PCM sample FIFO feeding a hold register and a saturating second-order delta-sigma PDM modulator.
// Define AUDIO_SDM_DITHER_EN to add +/-1 LFSR dither to the modulator input.
module audio_sdm_dac #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_data,
  input  logic                     stb_pcm,
  input  logic                     stb_mod,
  input  logic                     mute,
  output logic                     pdm_out,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = ACC_W + 2;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic signed [EW-1:0] SAT_HI = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_LO = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] FB_POS = {{(ACC_W-16){1'b0}}, 16'h7FFF};
  localparam logic signed [ACC_W-1:0] FB_NEG = {{(ACC_W-16){1'b1}}, 16'h8000};

  logic [15:0]              mem_r [DEPTH];
  logic [AW-1:0]            wr_ptr_r;
  logic [AW-1:0]            rd_ptr_r;
  logic [LW-1:0]            level_r;
  logic signed [15:0]       hold_r;
  logic                     underrun_r;
  logic signed [ACC_W-1:0]  i1_r;
  logic signed [ACC_W-1:0]  i2_r;
  logic                     pdm_r;

  logic                     empty_s;
  logic                     full_s;
  logic                     wr_en_s;
  logic                     rd_en_s;
  logic signed [ACC_W-1:0]  x_s;
  logic signed [ACC_W-1:0]  fb_s;
  logic signed [ACC_W-1:0]  i1_nxt_s;
  logic signed [ACC_W-1:0]  i2_nxt_s;

`ifdef AUDIO_SDM_DITHER_EN
  logic [15:0] lfsr_r;
`endif

  function automatic logic signed [EW-1:0] widen(input logic signed [ACC_W-1:0] v);
    widen = {{2{v[ACC_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SAT_HI) begin
      sat = SAT_HI[ACC_W-1:0];
    end else if (v < SAT_LO) begin
      sat = SAT_LO[ACC_W-1:0];
    end else begin
      sat = v[ACC_W-1:0];
    end
  endfunction

  // FIFO status and handshake decode; full blocks writes even on a pop cycle
  always_comb begin
    empty_s = (level_r == {LW{1'b0}});
    full_s  = (level_r == FULL_LVL);
    wr_en_s = in_valid & ~full_s;
    rd_en_s = stb_pcm & ~empty_s;
  end

  // Modulator next-state: both integrators saturate, feedback uses the current pdm bit
  always_comb begin
    if (mute) begin
      x_s = {ACC_W{1'b0}};
    end else begin
      x_s = {{(ACC_W-16){hold_r[15]}}, hold_r};
    end
`ifdef AUDIO_SDM_DITHER_EN
    if (lfsr_r[0]) begin
      x_s = x_s + ACC_W'(1);
    end else begin
      x_s = x_s - ACC_W'(1);
    end
`endif
    fb_s     = pdm_r ? FB_POS : FB_NEG;
    i1_nxt_s = sat(widen(i1_r) + widen(x_s) - widen(fb_s));
    i2_nxt_s = sat(widen(i2_r) + widen(i1_nxt_s) - widen(fb_s));
  end

  // Sample storage; contents need no reset because the pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers, occupancy, hold register and underrun flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      hold_r     <= 16'sd0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= stb_pcm & empty_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        hold_r   <= mem_r[rd_ptr_r];
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Modulator state advances only on the modulator tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1_r   <= {ACC_W{1'b0}};
      i2_r   <= {ACC_W{1'b0}};
      pdm_r  <= 1'b0;
`ifdef AUDIO_SDM_DITHER_EN
      lfsr_r <= 16'hACE1;
`endif
    end else if (stb_mod) begin
      i1_r   <= i1_nxt_s;
      i2_r   <= i2_nxt_s;
      pdm_r  <= ~i2_nxt_s[ACC_W-1];
`ifdef AUDIO_SDM_DITHER_EN
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
`endif
    end
  end

  assign in_ready = ~full_s;
  assign pdm_out  = pdm_r;
  assign underrun = underrun_r;
  assign level    = level_r;

endmodule

// File: tb/tb_audio_sdm_dac.sv
// Randomized and directed bench for audio_sdm_dac against a cycle-level behavioural model.
module tb_audio_sdm_dac;

  localparam int DEPTH = 4;
  localparam int ACC_W = 24;
`ifdef AUDIO_SDM_DITHER_EN
  localparam int TOL_TIGHT = 8;
  localparam int TOL_MUTE  = 8;
`else
  localparam int TOL_TIGHT = 2;
  localparam int TOL_MUTE  = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        stb_pcm;
  logic        stb_mod;
  logic        mute;
  logic        pdm_out;
  logic        underrun;
  logic [2:0]  level;

  always #5 clk = ~clk;

  audio_sdm_dac #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .stb_pcm(stb_pcm), .stb_mod(stb_mod), .mute(mute),
    .pdm_out(pdm_out), .underrun(underrun), .level(level)
  );

  int checks = 0;
  int errors = 0;
  int ones   = 0;

  // behavioural model state
  int          q[$];
  longint      hold_m;
  longint      i1_m;
  longint      i2_m;
  bit          pdm_m;
  bit          und_m;
  logic [15:0] lfsr_m;

  localparam longint AMAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (ACC_W - 1));

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    hold_m = 0; i1_m = 0; i2_m = 0; pdm_m = 0; und_m = 0;
    lfsr_m = 16'hACE1;
  endtask

  task automatic step(input bit rst, input bit v, input logic [15:0] d,
                      input bit sp, input bit sm, input bit mu);
    longint x;
    longint fb;
    bit     acc;
    rst_n = rst; in_valid = v; in_data = d; stb_pcm = sp; stb_mod = sm; mute = mu;
    #1;
    check("in_ready", in_ready, (q.size() < DEPTH) ? 1 : 0);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (sm) begin
        x = mu ? 0 : hold_m;
`ifdef AUDIO_SDM_DITHER_EN
        x = x + (lfsr_m[0] ? 1 : -1);
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
        fb    = pdm_m ? 32767 : -32768;
        i1_m  = clamp(i1_m + x - fb);
        i2_m  = clamp(i2_m + i1_m - fb);
        pdm_m = (i2_m >= 0);
      end
      acc   = v && (q.size() < DEPTH);
      und_m = sp && (q.size() == 0);
      if (sp && q.size() > 0) hold_m = q.pop_front();
      if (acc) q.push_back(int'($signed(d)));
    end
    @(negedge clk);
    check("pdm_out", pdm_out, pdm_m);
    check("underrun", underrun, und_m);
    check("level", level, q.size());
    if (rst && sm) ones += int'(pdm_out);
  endtask

  task automatic load(input logic [15:0] v);
    step(1'b1, 1'b1, v, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_mod(input int n, input bit mu);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, mu);
  endtask

  task automatic density(input string tag, input logic [15:0] v, input int exp_ones, input int tol);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    load(v);
    ones = 0;
    run_mod(256, 1'b0);
    check(tag, (ones >= exp_ones - tol && ones <= exp_ones + tol) ? 1 : 0, 1);
  endtask

  logic [15:0] samples [4];

  initial begin
    samples[0] = 16'h0000; samples[1] = 16'h4000; samples[2] = 16'hC000; samples[3] = 16'h8000;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; stb_pcm = 1'b0; stb_mod = 1'b0; mute = 1'b0;
    model_reset();
    @(negedge clk);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("reset_level", level, 0);
    check("reset_pdm", pdm_out, 0);

    // fill to full with a fifth sample held off, then one pop lets it in
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'(i * 1000 + 7), 1'b0, 1'b0, 1'b0);
    check("full_level", level, 4);
    check("full_ready", in_ready, 0);
    step(1'b1, 1'b1, 16'd4007, 1'b1, 1'b0, 1'b0);
    check("pop_full_level", level, 3);
    step(1'b1, 1'b1, 16'd4007, 1'b0, 1'b0, 1'b0);
    check("refill_level", level, 4);

    // traffic, then a 3-cycle reset mid-stream with strobes active
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'($urandom), 1'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("post_rst_pdm", pdm_out, 0);
    check("post_rst_level", level, 0);
    check("post_rst_underrun", underrun, 0);

    // underrun on empty, single-cycle pulse, then write+pop on empty
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("underrun_pulse", underrun, 1);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("underrun_clear", underrun, 0);
    step(1'b1, 1'b1, 16'd123, 1'b1, 1'b0, 1'b0);
    check("wr_pop_empty_und", underrun, 1);
    check("wr_pop_empty_lvl", level, 1);

    // modulator densities
    density("dens_zero", samples[0], 128, TOL_TIGHT);
    density("dens_pos_half", samples[1], 192, TOL_TIGHT);
    density("dens_neg_half", samples[2], 64, TOL_TIGHT);

    // full-scale negative drive into saturation, tracked exactly by the model
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    load(samples[3]);
    run_mod(1000, 1'b0);

    // mute overrides a nonzero held sample
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    load(samples[1]);
    run_mod(64, 1'b1);
    ones = 0;
    run_mod(256, 1'b1);
    check("dens_mute", (ones >= 128 - TOL_MUTE && ones <= 128 + TOL_MUTE) ? 1 : 0, 1);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), 1'($urandom), 16'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
